// File: rtl/ddr_in_deserializer.sv
// ddr_in_deserializer: packs DDR pad sample pairs into words and aligns word boundaries by training hunt or manual bitslip
module ddr_in_deserializer #(
    parameter int                WORD_W        = 8,
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'h5C,
    parameter int                LOCK_COUNT    = 4
) (
    input  logic              C,
    input  logic              R,
    input  logic              CE,
    input  logic              Q0,
    input  logic              Q1,
    input  logic              TRAIN_EN,
    input  logic              BITSLIP,
    output logic [WORD_W-1:0] DOUT,
    output logic              DVALID,
    output logic              LOCKED,
    output logic              ALIGN_FAIL
);
    localparam int HW = WORD_W / 2;
    localparam int PW = (HW > 1) ? $clog2(HW) : 1;
    localparam int OW = $clog2(WORD_W);
    localparam int SW = $clog2(2 * WORD_W);

    typedef enum logic [1:0] {ST_HUNT, ST_SETTLE, ST_LOCKED} state_t;

    state_t              state_q, state_d;
    logic [2*WORD_W-1:0] sr_q, sr_d, sr_nx;
    logic [PW-1:0]       ph_q, ph_d;
    logic [OW-1:0]       off_q, off_d, off_inc;
    logic [3:0]          match_q, match_d;
    logic [SW-1:0]       slip_q, slip_d;
    logic [WORD_W-1:0]   dout_q, dout_d, word;
    logic                dvalid_q, dvalid_d, locked_q, locked_d, fail_q, fail_d, train_q, train_d;
    logic                bnd, hit;

    assign DOUT       = dout_q;
    assign DVALID     = dvalid_q;
    assign LOCKED     = locked_q;
    assign ALIGN_FAIL = fail_q;

    // next state: shift/phase/word extraction every CE cycle, FSM only at training boundaries
    always_comb begin
        sr_nx    = {sr_q[2*WORD_W-3:0], Q0, Q1};
        word     = WORD_W'(sr_nx >> off_q);
        bnd      = ph_q == PW'(HW - 1);
        hit      = word == TRAIN_PATTERN;
        off_inc  = (off_q == OW'(WORD_W - 1)) ? '0 : off_q + 1'b1;
        state_d  = state_q;
        sr_d     = sr_q;
        ph_d     = ph_q;
        off_d    = off_q;
        match_d  = match_q;
        slip_d   = slip_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        locked_d = locked_q;
        fail_d   = fail_q;
        train_d  = train_q;
        if (CE) begin
            sr_d    = sr_nx;
            ph_d    = bnd ? '0 : ph_q + 1'b1;
            train_d = TRAIN_EN;
            if (bnd) begin
                dout_d   = word;
                dvalid_d = 1'b1;
            end
            if (TRAIN_EN && !train_q) begin
                state_d  = ST_HUNT;
                match_d  = '0;
                slip_d   = '0;
                locked_d = 1'b0;
            end else if (TRAIN_EN && bnd) begin
                case (state_q)
                    ST_HUNT: begin
                        if (hit) begin
                            match_d = match_q + 4'd1;
                            if (match_q == 4'(LOCK_COUNT - 1)) begin
                                locked_d = 1'b1;
                                match_d  = '0;
                                state_d  = ST_LOCKED;
                            end
                        end else begin
                            match_d = '0;
                            off_d   = off_inc;
                            state_d = ST_SETTLE;
                            slip_d  = (slip_q == SW'(2 * WORD_W - 1)) ? '0 : slip_q + 1'b1;
                            fail_d  = fail_q | (slip_q == SW'(2 * WORD_W - 1));
                        end
                    end
                    ST_SETTLE: state_d = ST_HUNT;
                    default: begin
                        if (!hit) begin
                            locked_d = 1'b0;
                            match_d  = '0;
                            state_d  = ST_HUNT;
                        end
                    end
                endcase
            end else if (!TRAIN_EN && BITSLIP) begin
                off_d = off_inc;
            end
        end
    end

    // state register with synchronous reset taking priority over CE
    always_ff @(posedge C) begin
        if (R) begin
            state_q  <= ST_HUNT;
            sr_q     <= '0;
            ph_q     <= '0;
            off_q    <= '0;
            match_q  <= '0;
            slip_q   <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            train_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            ph_q     <= ph_d;
            off_q    <= off_d;
            match_q  <= match_d;
            slip_q   <= slip_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
            train_q  <= train_d;
        end
    end
endmodule
